mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit mux channel between four requesters.
- Decides which requester owns the channel, drives the mux select lines (sel1:sel0 = owner index), and issues a one-hot grant.
- Supports bounded bursts with an optional lock, so a requester can hold the channel across a multi-cycle transfer.
- Sits directly in front of the 4:1 mux built from 2:1 stages; its sel0/sel1 outputs connect straight to that mux's select inputs.

Parameters:
- BURST_LEN, 4: maximum consecutive cycles an owner keeps the grant while another requester waits. Legal range 1..2^CW-1.
- CW, 3: width of the burst counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  request vector; req[i] high = requester i wants the channel.
- lock  in  1  while high in GRANT with req[owner] high, suppresses burst-limit rotation.
- gnt  out  4  one-hot grant, registered; all zero when idle.
- sel0  out  1  mux select LSB (owner index bit 0), registered.
- sel1  out  1  mux select MSB (owner index bit 1), registered.
- busy  out  1  high while any grant is active.
- owner  out  2  index of the current or most recent owner.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately with no clock edge):
  - gnt=0000, sel0=0, sel1=0, busy=0, owner=00.
  - Burst counter cnt=0; state=IDLE.
  - Internal last-winner pointer=3, so index 0 has top priority after reset.
- Round-robin pick: search indices (last+1) mod 4, (last+2) mod 4, ... and take the first with req high. On every new grant, last becomes the new owner.
- Invariants:
  - {sel1,sel0} == owner at all times.
  - gnt is either zero or exactly one-hot with gnt[owner]=1.
  - busy == |gnt.
- IDLE state:
  - If any req is high at edge N, a grant is registered at edge N (visible in cycle N+1; one-cycle latency) and the state moves to GRANT with cnt=1.
  - If no req is high, outputs hold: sel/owner keep the last owner and do not return to 00, so the mux select never toggles while idle.
- GRANT state, evaluated each edge in this priority order:
  1. req[owner]=0, other requests pending: hand over to the next round-robin winner at that same edge. No idle gap; cnt=1.
  2. req[owner]=0, no other requests: go to IDLE. gnt=0, busy=0, sel/owner hold.
  3. req[owner]=1, lock=1: hold the grant. cnt saturates at BURST_LEN.
  4. req[owner]=1, lock=0, cnt==BURST_LEN, another req pending: hand over to the next round-robin winner; cnt=1.
  5. Otherwise: hold the grant; cnt=min(cnt+1, BURST_LEN).
- Without contention, an owner keeps the grant indefinitely; cnt stays saturated.
- lock is ignored in IDLE and cannot claim a grant by itself.
- Lock release with a saturated counter: if lock falls while cnt==BURST_LEN and others are waiting, rotation happens at the next edge.
- BURST_LEN=1: the grant rotates every cycle under full contention.
- Requests may change every cycle; no request stability is required. Outputs depend only on req/lock sampled at the edge, with no combinational paths from inputs to outputs.
- A single requester re-requests after release: it is re-granted with IDLE latency, and the round-robin pointer still favours others on contention.

Test Plan:
- Reset: hold rst_n=0 mid-simulation with no clock edge -> gnt=0000, sel1:sel0=00, busy=0 immediately; after release with req=1111, first gnt=0001.
- Single requester: req=0100 for 10 cycles -> gnt=0100, sel1=1, sel0=0, busy=1 from the cycle after first sampling, held all 10 cycles; drop req -> next cycle gnt=0000, busy=0, sel stays 10.
- Full contention, BURST_LEN=4, req=1111 for 20 cycles -> grant order 0,1,2,3,0, each exactly 4 cycles, no gap cycles, sel tracks the index each cycle.
- Lock: req=0011, owner=0, lock=1 for 8 cycles -> gnt=0001 for all 8 cycles; lock falls -> gnt=0010 at the next edge.
- Early release handover: owner 1 with req=1010 drops req[1] after 2 cycles -> next edge gnt=1000, sel=11, owner=3, no idle cycle.
- Async reset mid-burst: owner 2 holds gnt; pulse rst_n low between clock edges -> gnt=0000 and sel=00 instantly; after release with req=0100 -> gnt=0100 after one cycle.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant and mux-select bundle between requesters and the arbiter.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       lock;
  logic [3:0] gnt;
  logic       sel0;
  logic       sel1;
  logic       busy;
  logic [1:0] owner;
  modport master (output req, lock, input gnt, sel0, sel1, busy, owner);
  modport slave  (input req, lock, output gnt, sel0, sel1, busy, owner);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a 4:1 mux channel with bounded, lockable bursts.
module mux4_rr_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CW        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_sat;
  logic [1:0]    own, own_nx, last, last_nx, win;
  logic [3:0]    gnt, gnt_nx, cand;
  logic          found, handover, idle_go;
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    res = 3'b000;
    // Scan farthest offset first so the nearest requester after p wins.
    for (int k = 4; k >= 1; k--) begin
      if (r[p + 2'(k)]) res = {1'b1, p + 2'(k)};
    end
    return res;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      own   <= 2'd0;
      last  <= 2'd3;
      gnt   <= 4'b0000;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      own   <= own_nx;
      last  <= last_nx;
      gnt   <= gnt_nx;
    end
  end
  always_comb begin
    cand            = (state == GRANT) ? bus.req & ~(4'b0001 << own) : bus.req;
    {found, win}    = rr_pick(cand, last);
    cnt_sat         = (cnt == CW'(BURST_LEN)) ? cnt : cnt + 1'b1;
    handover        = found & ((state == IDLE) | ~bus.req[own] | (~bus.lock & (cnt == CW'(BURST_LEN))));
    idle_go         = (state == GRANT) & ~bus.req[own] & ~found;
    state_nx        = handover ? GRANT : idle_go ? IDLE : state;
    cnt_nx          = handover ? CW'(1) : (idle_go | (state == IDLE)) ? '0 : cnt_sat;
    own_nx          = handover ? win : own;
    last_nx         = handover ? win : last;
    gnt_nx          = handover ? 4'b0001 << win : idle_go ? 4'b0000 : gnt;
  end
  always_comb begin
    bus.gnt   = gnt;
    bus.sel0  = own[0];
    bus.sel1  = own[1];
    bus.owner = own;
    bus.busy  = |gnt;
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench comparing the arbiter against a cycle model.
module tb_mux4_rr_arbiter;
  localparam int BL = 4;
  typedef struct {
    logic [3:0] gnt;
    logic [1:0] own;
    logic       busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int m_own, m_last, m_cnt;
  bit m_busy;
  exp_t sb[$];
  mux4_rr_arbiter_if bus();
  mux4_rr_arbiter #(.BURST_LEN(BL), .CW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_rst(input string tag);
    check({tag, "_gnt"}, bus.gnt, 4'b0000);
    check({tag, "_sel"}, {2'b00, bus.sel1, bus.sel0}, 4'b0000);
    check({tag, "_owner"}, {2'b00, bus.owner}, 4'b0000);
    check({tag, "_busy"}, {3'b000, bus.busy}, 4'b0000);
  endtask
  task automatic model_reset();
    m_own = 0; m_last = 3; m_cnt = 0; m_busy = 0;
  endtask
  task automatic model_grant(input int w);
    m_own = w; m_last = w; m_cnt = 1; m_busy = 1;
  endtask
  task automatic model(input logic [3:0] r, input logic l);
    int w;
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (m_last + k) % 4;
      if (w < 0 && r[i] && !(m_busy && i == m_own)) w = i;
    end
    if (!m_busy) begin
      if (w >= 0) model_grant(w);
    end else if (!r[m_own]) begin
      if (w >= 0) model_grant(w);
      else begin m_busy = 0; m_cnt = 0; end
    end else if (l) m_cnt = (m_cnt < BL) ? m_cnt + 1 : BL;
    else if (m_cnt == BL && w >= 0) model_grant(w);
    else m_cnt = (m_cnt < BL) ? m_cnt + 1 : BL;
  endtask
  task automatic step(input logic [3:0] r, input logic l);
    exp_t e;
    bus.req = r;
    bus.lock = l;
    model(r, l);
    e.gnt = m_busy ? 4'(1 << m_own) : 4'b0000;
    e.own = 2'(m_own);
    e.busy = m_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt", bus.gnt, e.gnt);
    check("sel", {2'b00, bus.sel1, bus.sel0}, {2'b00, e.own});
    check("owner", {2'b00, bus.owner}, {2'b00, e.own});
    check("busy", {3'b000, bus.busy}, {3'b000, e.busy});
  endtask
  initial begin
    bus.req = 4'b0000;
    bus.lock = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_rst("por");
    #11 rst_n = 1'b1;
    step(4'b1111, 1'b0);
    check("first_gnt", bus.gnt, 4'b0001);
    repeat (19) step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);
    repeat (10) step(4'b0100, 1'b0);
    check("single_sel", {2'b00, bus.sel1, bus.sel0}, 4'b0010);
    step(4'b0000, 1'b0);
    check("release_busy", {3'b000, bus.busy}, 4'b0000);
    check("release_sel", {2'b00, bus.sel1, bus.sel0}, 4'b0010);
    repeat (8) step(4'b0011, 1'b1);
    check("lock_hold", bus.gnt, 4'b0001);
    step(4'b0011, 1'b0);
    check("lock_release", bus.gnt, 4'b0010);
    repeat (2) step(4'b1010, 1'b0);
    step(4'b1000, 1'b0);
    check("early_gnt", bus.gnt, 4'b1000);
    check("early_owner", {2'b00, bus.owner}, 4'b0011);
    step(4'b0000, 1'b0);
    repeat (3) step(4'b0100, 1'b0);
    #3 rst_n = 1'b0;
    #1 check_rst("async");
    model_reset();
    #1 rst_n = 1'b1;
    step(4'b0100, 1'b0);
    check("post_rst", bus.gnt, 4'b0100);
    repeat (300) begin
      logic [3:0] r;
      r = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      step(r, $urandom_range(0, 3) == 0);
    end
    step(4'b0000, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
